// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ctrl_pkg: shared opcodes, states and instruction field layout    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_SUB   = 3'b001,
    OP_ADD   = 3'b010,
    OP_ASC   = 3'b011,
    OP_DESC  = 3'b100,
    OP_LOADI = 3'b101
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SORT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] ALU_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_OP_SUB  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD  = 3'b010;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_regfile: 8x4 register file, two operand reads, debug read,       |
// | two write ports for swapping a register pair in one edge. Rev 1.0    |
// +----------------------------------------------------------------------+
module alu_regfile (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rd_addr_a,
  output logic [3:0] rd_data_a,
  input  logic [2:0] rd_addr_b,
  output logic [3:0] rd_data_b,
  input  logic [2:0] dbg_addr,
  output logic [3:0] dbg_data,
  input  logic       we_a,
  input  logic [2:0] waddr_a,
  input  logic [3:0] wdata_a,
  input  logic       we_b,
  input  logic [2:0] waddr_b,
  input  logic [3:0] wdata_b
);

  logic [7:0][3:0] regs_q;
  logic [7:0][3:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we_a) regs_d[waddr_a] = wdata_a;
    if (we_b) regs_d[waddr_b] = wdata_b;
  end

  for (genvar g = 0; g < 8; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) regs_q[g] <= 4'd0;
      else       regs_q[g] <= regs_d[g];
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign dbg_data  = regs_q[dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer: instruction controller for the 4-bit ALU; ADD/SUB via |
// | the external ALU, range sorts as in-place bubble sort. Rev 1.0       |
// +----------------------------------------------------------------------+
module alu_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_instr,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [3:0]  dbg_data
);

  state_e      state_q, state_d;
  logic [11:0] instr_q, instr_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  hi_q, hi_d;
  logic        swapped_q, swapped_d;

  logic [2:0]  op_q, rd_q, ra_q;
  logic [2:0]  in_op, in_rd, in_ra, in_rb;
  logic [3:0]  in_imm;
  logic [2:0]  idx_next;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [3:0]  rd_data_a, rd_data_b;
  logic        we_a, we_b;
  logic [2:0]  waddr_a, waddr_b;
  logic [3:0]  wdata_a, wdata_b;
  logic        do_swap, swapped_now;

  assign op_q   = instr_q[OP_MSB:OP_LSB];
  assign rd_q   = instr_q[RD_MSB:RD_LSB];
  assign ra_q   = instr_q[RA_MSB:RA_LSB];
  assign in_op  = in_instr[OP_MSB:OP_LSB];
  assign in_rd  = in_instr[RD_MSB:RD_LSB];
  assign in_ra  = in_instr[RA_MSB:RA_LSB];
  assign in_rb  = in_instr[RB_MSB:RB_LSB];
  assign in_imm = in_instr[IMM_MSB:IMM_LSB];

  assign idx_next = idx_q + 3'd1;

  // Read ports follow the sort cursor during SORT, otherwise the operand fields.
  assign rd_addr_a = (state_q == ST_SORT) ? idx_q    : ra_q;
  assign rd_addr_b = (state_q == ST_SORT) ? idx_next : instr_q[RB_MSB:RB_LSB];

  alu_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .we_a      (we_a),
    .waddr_a   (waddr_a),
    .wdata_a   (wdata_a),
    .we_b      (we_b),
    .waddr_b   (waddr_b),
    .wdata_b   (wdata_b)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    swapped_d   = swapped_q;
    we_a        = 1'b0;
    waddr_a     = rd_q;
    wdata_a     = alu_result;
    we_b        = 1'b0;
    waddr_b     = idx_next;
    wdata_b     = rd_data_a;
    do_swap     = 1'b0;
    swapped_now = swapped_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          case (in_op)
            OP_ADD, OP_SUB: state_d = ST_EXEC;
            OP_ASC, OP_DESC: begin
              if (in_ra < in_rb) begin
                state_d   = ST_SORT;
                idx_d     = in_ra;
                hi_d      = in_rb;
                swapped_d = 1'b0;
              end else begin
                state_d = ST_DONE;
              end
            end
            OP_LOADI: begin
              we_a    = 1'b1;
              waddr_a = in_rd;
              wdata_a = in_imm;
              state_d = ST_DONE;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_EXEC: begin
        we_a    = 1'b1;
        state_d = ST_DONE;
      end
      ST_SORT: begin
        do_swap = (op_q == OP_ASC) ? (rd_data_a > rd_data_b) : (rd_data_a < rd_data_b);
        if (do_swap) begin
          we_a    = 1'b1;
          waddr_a = idx_q;
          wdata_a = rd_data_b;
          we_b    = 1'b1;
        end
        swapped_now = swapped_q | do_swap;
        if (idx_next < hi_q) begin
          idx_d     = idx_next;
          swapped_d = swapped_now;
        end else if (!swapped_now || ((hi_q - 3'd1) == ra_q)) begin
          state_d = ST_DONE;
        end else begin
          // Largest (or smallest) element has settled at hi; shrink the pass.
          hi_d      = hi_q - 3'd1;
          idx_d     = ra_q;
          swapped_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= 12'd0;
      idx_q     <= 3'd0;
      hi_q      <= 3'd0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      swapped_q <= swapped_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = done & op_q[2] & op_q[1];
  assign alu_op   = (state_q != ST_EXEC) ? ALU_OP_NONE :
                    (op_q == OP_SUB)     ? ALU_OP_SUB  : ALU_OP_ADD;
  assign alu_a    = (state_q == ST_EXEC) ? rd_data_a : 4'd0;
  assign alu_b    = (state_q == ST_EXEC) ? rd_data_b : 4'd0;

endmodule : alu_sequencer
`default_nettype wire
